// File: rtl/seg_pkg.sv
// Shared constants and register layouts for the seven-segment scan controller.
// Holds the register map, CTRL bit positions and the hex font.
package seg_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 16;

   localparam logic [ADDR_W-1:0] ADDR_DIGIT_BASE = 4'd0;
   localparam logic [ADDR_W-1:0] ADDR_CTRL       = 4'd8;
   localparam logic [ADDR_W-1:0] ADDR_STATUS     = 4'd9;

   localparam int unsigned CTRL_EN_BIT    = 0;
   localparam int unsigned CTRL_HEX_BIT   = 1;
   localparam int unsigned CTRL_BLANK_LSB = 8;

   // Active-high {g..a} patterns, entry 15 first so HEX_FONT[n] is digit n.
   localparam logic [15:0][6:0] HEX_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef struct packed {
      logic [3:0] nibble;
      logic       dp;
      logic [6:0] raw;
   } digit_reg_t;

   typedef struct packed {
      logic [7:0] blank;
      logic       hex;
      logic       en;
   } ctrl_reg_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Avalon-MM slave bus bundle for the segment scan controller.
interface seg_scan_ctrl_if;
   import seg_pkg::*;

   logic [ADDR_W-1:0] slave_address;
   logic              slave_read;
   logic              slave_write;
   logic [DATA_W-1:0] slave_writedata;
   logic [1:0]        slave_byteenable;
   logic [DATA_W-1:0] slave_readdata;

   modport master (
      output slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
      input  slave_readdata
   );

   modport slave (
      input  slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
      output slave_readdata
   );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_c
);

   assign seg_c = HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Register-mapped seven-segment bank: static per-digit buses plus a
// time-multiplexed scan bus with digit select and anti-ghosting blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned BLANK_CYC  = 16,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   seg_scan_ctrl_if.slave          bus,
   output logic [8*NUM_DIGITS-1:0] seg_static,
   output logic [7:0]              seg_scan,
   output logic [NUM_DIGITS-1:0]   digit_sel
);

   localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = 3;
   localparam logic [7:0]  SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = ACTIVE_LOW ? '1 : '0;

   digit_reg_t digit_q [NUM_DIGITS];
   digit_reg_t digit_d [NUM_DIGITS];
   ctrl_reg_t  ctrl_q, ctrl_d;
   logic [PW-1:0]           presc_q, presc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic [8*NUM_DIGITS-1:0] static_q, static_d;
   logic [7:0]              scan_q, scan_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;

   logic [6:0] font_c [NUM_DIGITS];
   logic [7:0] pat_c  [NUM_DIGITS];
   logic       in_blank_c;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg_hex_decode u_dec (.nibble(digit_q[g].nibble), .seg_c(font_c[g]));
   end

   assign in_blank_c = ctrl_q.en && (32'(presc_q) < BLANK_CYC);

   // Active-high digit patterns after source select and enable/blank gating.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         pat_c[i] = {digit_q[i].dp, ctrl_q.hex ? font_c[i] : digit_q[i].raw};
         if (!ctrl_q.en || ctrl_q.blank[i]) pat_c[i] = 8'h00;
      end
   end

   // Register file writes and registered read mux.
   always_comb begin
      digit_d = digit_q;
      ctrl_d  = ctrl_q;
      rdata_d = rdata_q;
      if (bus.slave_write) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.slave_address == ADDR_DIGIT_BASE + 4'(i)) begin
               if (bus.slave_byteenable[0]) begin
                  digit_d[i].dp  = bus.slave_writedata[7];
                  digit_d[i].raw = bus.slave_writedata[6:0];
               end
               if (bus.slave_byteenable[1]) digit_d[i].nibble = bus.slave_writedata[11:8];
            end
         end
         if (bus.slave_address == ADDR_CTRL) begin
            if (bus.slave_byteenable[0]) begin
               ctrl_d.en  = bus.slave_writedata[CTRL_EN_BIT];
               ctrl_d.hex = bus.slave_writedata[CTRL_HEX_BIT];
            end
            if (bus.slave_byteenable[1]) ctrl_d.blank = bus.slave_writedata[CTRL_BLANK_LSB +: 8];
         end
      end
      if (bus.slave_read) begin
         rdata_d = '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.slave_address == ADDR_DIGIT_BASE + 4'(i)) rdata_d = {4'h0, digit_q[i]};
         end
         if (bus.slave_address == ADDR_CTRL) rdata_d = {ctrl_q.blank, 6'h00, ctrl_q.hex, ctrl_q.en};
         if (bus.slave_address == ADDR_STATUS) rdata_d = {12'h000, in_blank_c, idx_q};
      end
   end

   // Prescaler and scan index; both held at zero while disabled.
   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (!ctrl_q.en) begin
         presc_d = '0;
         idx_d   = '0;
      end else if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   // Output registers; select and segments come from the same counter state.
   always_comb begin
      static_d = '0;
      scan_d   = 8'h00;
      sel_d    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         static_d[8*i +: 8] = pat_c[i] ^ SEG_OFF;
         if (ctrl_q.en && idx_q == IW'(i)) begin
            sel_d[i] = 1'b1;
            if (!in_blank_c) scan_d = pat_c[i];
         end
      end
      scan_d = scan_d ^ SEG_OFF;
      sel_d  = sel_d ^ SEL_OFF;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
         ctrl_q   <= '0;
         presc_q  <= '0;
         idx_q    <= '0;
         rdata_q  <= '0;
         static_q <= {NUM_DIGITS{SEG_OFF}};
         scan_q   <= SEG_OFF;
         sel_q    <= SEL_OFF;
      end else begin
         digit_q  <= digit_d;
         ctrl_q   <= ctrl_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         rdata_q  <= rdata_d;
         static_q <= static_d;
         scan_q   <= scan_d;
         sel_q    <= sel_d;
      end
   end

   assign bus.slave_readdata = rdata_q;
   assign seg_static         = static_q;
   assign seg_scan           = scan_q;
   assign digit_sel          = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (4 digits, short scan slots).
module tb_seg_scan_ctrl;
   import seg_pkg::*;

   localparam int unsigned ND = 4;
   localparam int unsigned SD = 8;
   localparam int unsigned BC = 2;

   logic          clk;
   logic          reset_n;
   logic [31:0]   seg_static;
   logic [7:0]    seg_scan;
   logic [3:0]    digit_sel;
   int            checks;
   int            failures;
   logic [7:0]    pat_exp [4];

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .seg_static(seg_static), .seg_scan(seg_scan), .digit_sel(digit_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      @(negedge clk);
      bus.slave_address = a; bus.slave_writedata = d; bus.slave_byteenable = be;
      bus.slave_write = 1'b1;
      @(negedge clk);
      bus.slave_write = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
      @(negedge clk);
      bus.slave_address = a; bus.slave_read = 1'b1;
      @(negedge clk);
      bus.slave_read = 1'b0;
      d = bus.slave_readdata;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.slave_address = '0; bus.slave_read = 1'b0; bus.slave_write = 1'b0;
      bus.slave_writedata = '0; bus.slave_byteenable = '0;
      repeat (3) @(negedge clk);
      checks++; if (seg_static !== 32'hFFFFFFFF) begin failures++; $display("FAIL reset_static got=%h exp=%h", seg_static, 32'hFFFFFFFF); end
      checks++; if (seg_scan !== 8'hFF) begin failures++; $display("FAIL reset_scan got=%h exp=ff", seg_scan); end
      checks++; if (digit_sel !== 4'hF) begin failures++; $display("FAIL reset_sel got=%h exp=f", digit_sel); end
      checks++; if (bus.slave_readdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", bus.slave_readdata); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_hex_write();
      logic [15:0] rd;
      bus_write(ADDR_CTRL, 16'h0003, 2'b11);
      bus_write(4'd2, 16'h0A00, 2'b11);
      @(negedge clk);
      checks++; if (seg_static[23:16] !== 8'h88) begin failures++; $display("FAIL hex_digit2 got=%h exp=88", seg_static[23:16]); end
      checks++; if (seg_static !== 32'hC088C0C0) begin failures++; $display("FAIL hex_all got=%h exp=c088c0c0", seg_static); end
      bus_read(ADDR_CTRL, rd);
      checks++; if (rd !== 16'h0003) begin failures++; $display("FAIL read_ctrl got=%h exp=0003", rd); end
      bus_read(4'd2, rd);
      checks++; if (rd !== 16'h0A00) begin failures++; $display("FAIL read_digit2 got=%h exp=0a00", rd); end
   endtask

   task automatic test_byte_lanes();
      logic [15:0] rd;
      bus_write(4'd1, 16'hFF86, 2'b01);
      bus_read(4'd1, rd);
      checks++; if (rd !== 16'h0086) begin failures++; $display("FAIL be_low_read got=%h exp=0086", rd); end
      checks++; if (seg_static[15:8] !== 8'h40) begin failures++; $display("FAIL be_hex_dp got=%h exp=40", seg_static[15:8]); end
      bus_write(ADDR_CTRL, 16'h0001, 2'b01);
      @(negedge clk);
      checks++; if (seg_static[15:8] !== 8'h79) begin failures++; $display("FAIL be_raw_dp got=%h exp=79", seg_static[15:8]); end
      bus_write(4'd1, 16'h5C00, 2'b10);
      bus_read(4'd1, rd);
      checks++; if (rd !== 16'h0C86) begin failures++; $display("FAIL be_high_read got=%h exp=0c86", rd); end
   endtask

   task automatic test_scan();
      logic [15:0] rd;
      logic [3:0]  es;
      logic [7:0]  ep;
      int          slot;
      bus_write(ADDR_CTRL, 16'h0000, 2'b11);
      bus_write(4'd0, 16'h0001, 2'b11);
      bus_write(4'd1, 16'h0002, 2'b11);
      bus_write(4'd2, 16'h0004, 2'b11);
      bus_write(4'd3, 16'h0008, 2'b11);
      bus_write(ADDR_CTRL, 16'h0001, 2'b11);
      for (int k = 0; k < 52; k++) begin
         @(negedge clk);
         slot = (k / SD) % ND;
         es = ~(4'b0001 << slot);
         ep = ((k % SD) < BC) ? 8'hFF : pat_exp[slot];
         checks++; if (digit_sel !== es) begin failures++; $display("FAIL scan_sel k=%0d got=%b exp=%b", k, digit_sel, es); end
         checks++; if (seg_scan !== ep) begin failures++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg_scan, ep); end
      end
      bus_write(ADDR_CTRL, 16'h0000, 2'b01);
      checks++; if (digit_sel !== 4'hB || seg_scan !== 8'hFB) begin failures++; $display("FAIL clr_last sel=%h seg=%h exp=b/fb", digit_sel, seg_scan); end
      @(negedge clk);
      checks++; if (digit_sel !== 4'hF || seg_scan !== 8'hFF) begin failures++; $display("FAIL clr_off sel=%h seg=%h exp=f/ff", digit_sel, seg_scan); end
      bus_read(ADDR_STATUS, rd);
      checks++; if (rd[2:0] !== 3'd0) begin failures++; $display("FAIL clr_status_idx got=%0d exp=0", rd[2:0]); end
      bus_write(ADDR_CTRL, 16'h0001, 2'b01);
      checks++; if (digit_sel !== 4'hF) begin failures++; $display("FAIL restart_pre sel=%h exp=f", digit_sel); end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         slot = k / SD;
         es = ~(4'b0001 << slot);
         ep = ((k % SD) < BC) ? 8'hFF : pat_exp[slot];
         checks++; if (digit_sel !== es || seg_scan !== ep) begin failures++; $display("FAIL restart k=%0d sel=%b seg=%h exp=%b/%h", k, digit_sel, seg_scan, es, ep); end
      end
      bus_read(ADDR_STATUS, rd);
      checks++; if (rd !== 16'h000A) begin failures++; $display("FAIL status got=%h exp=000a", rd); end
      bus_write(ADDR_CTRL, 16'h0201, 2'b11);
      @(negedge clk);
      checks++; if (seg_static !== 32'hF7FBFFFE) begin failures++; $display("FAIL blank_mask got=%h exp=f7fbfffe", seg_static); end
   endtask

   task automatic test_unmapped();
      logic [15:0] rd;
      bus_write(4'd7, 16'hFFFF, 2'b11);
      bus_write(4'd12, 16'hFFFF, 2'b11);
      bus_write(4'd4, 16'hFFFF, 2'b11);
      bus_write(ADDR_STATUS, 16'hFFFF, 2'b11);
      bus_read(4'd7, rd);
      checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL read_addr7 got=%h exp=0000", rd); end
      bus_read(4'd12, rd);
      checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL read_addr12 got=%h exp=0000", rd); end
      bus_read(4'd4, rd);
      checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL read_addr4 got=%h exp=0000", rd); end
      bus_read(4'd3, rd);
      checks++; if (rd !== 16'h0008) begin failures++; $display("FAIL digit3_kept got=%h exp=0008", rd); end
      bus_read(ADDR_CTRL, rd);
      checks++; if (rd !== 16'h0201) begin failures++; $display("FAIL ctrl_kept got=%h exp=0201", rd); end
      @(negedge clk);
      checks++; if (seg_static !== 32'hF7FBFFFE) begin failures++; $display("FAIL static_kept got=%h exp=f7fbfffe", seg_static); end
   endtask

   task automatic test_async_reset();
      logic [15:0] rd;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (seg_static !== 32'hFFFFFFFF) begin failures++; $display("FAIL arst_static got=%h exp=ffffffff", seg_static); end
      checks++; if (seg_scan !== 8'hFF || digit_sel !== 4'hF) begin failures++; $display("FAIL arst_scan seg=%h sel=%h exp=ff/f", seg_scan, digit_sel); end
      checks++; if (bus.slave_readdata !== 16'h0000) begin failures++; $display("FAIL arst_rdata got=%h exp=0000", bus.slave_readdata); end
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(ADDR_CTRL, rd);
      checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL arst_ctrl got=%h exp=0000", rd); end
      bus_read(4'd0, rd);
      checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL arst_digit0 got=%h exp=0000", rd); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      pat_exp[0] = 8'hFE; pat_exp[1] = 8'hFD; pat_exp[2] = 8'hFB; pat_exp[3] = 8'hF7;
      test_reset();
      test_hex_write();
      test_byte_lanes();
      test_scan();
      test_unmapped();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
